// File: rtl/entropy_collector.sv
// entropy_collector -- packs raw ring-oscillator samples into words and
// buffers them in a first-word fall-through FIFO.
//
// Parameters:
//   WORD_WIDTH  bits per output word (2..32)
//   FIFO_DEPTH  output FIFO entries (power of two, >= 2)
//   DEBIAS      1 = von Neumann pair de-bias, 0 = one raw bit per cycle
//   REP_LIMIT   repetition-count threshold for the health test (2..255)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   raw_bit       raw entropy sample, taken every cycle
//   out_word      FIFO head word (valid while out_valid)
//   out_valid     FIFO holds at least one word
//   out_ready     consumer accepts head word when out_valid is also high
//   fifo_level    words currently stored
//   overflow_cnt  completed words dropped on a full FIFO (saturating)
//   health_fail   sticky repetition-count failure flag
//
// Optional feature: define RNG_HEALTH_TEST_EN to build the repetition-count
// health test; without it health_fail is tied low and collection never stops.
module entropy_collector #(
   parameter int unsigned WORD_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DEBIAS     = 1,
   parameter int unsigned REP_LIMIT  = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          raw_bit,
   output logic [WORD_WIDTH-1:0]         out_word,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   overflow_cnt,
   output logic                          health_fail
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(WORD_WIDTH);

   typedef enum logic {PH_FIRST, PH_SECOND} phase_t;

   phase_t                  phase;
   logic                    first_sample;
   logic                    bit_valid;
   logic                    bit_val;
   logic                    collect_en;
   logic                    accept;
   logic                    last_bit;
   logic                    word_wr;
   logic                    wr_ok;
   logic                    drop;
   logic                    full;
   logic                    pop;
   logic [WORD_WIDTH-1:0]   acc;
   logic [WORD_WIDTH-1:0]   new_word;
   logic [CNT_W-1:0]        bit_cnt;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [WORD_WIDTH-1:0]   mem [FIFO_DEPTH];

   // Pair phase and stored first sample of each pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase        <= PH_FIRST;
         first_sample <= 1'b0;
      end else begin
         phase <= (phase == PH_FIRST) ? PH_SECOND : PH_FIRST;
         if (phase == PH_FIRST)
            first_sample <= raw_bit;
      end
   end

   // Von Neumann: 01 -> 1, 10 -> 0, so the emitted bit equals the second sample.
   always_comb begin
      bit_val = raw_bit;
      if (DEBIAS != 0)
         bit_valid = (phase == PH_SECOND) && (raw_bit != first_sample);
      else
         bit_valid = 1'b1;
   end

   assign accept   = bit_valid && collect_en;
   assign last_bit = (bit_cnt == CNT_W'(WORD_WIDTH - 1));
   assign word_wr  = accept && last_bit;
   // Bits below the top are all refreshed during the current word.
   assign new_word = {bit_val, acc[WORD_WIDTH-2:0]};

   assign out_valid = (fifo_level != '0);
   assign full      = (fifo_level == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
   assign pop       = out_valid && out_ready;
   // A simultaneous pop frees the slot, so a write on a full FIFO still lands.
   assign wr_ok     = word_wr && (!full || pop);
   assign drop      = word_wr && full && !pop;
   assign out_word  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         bit_cnt <= '0;
      end else if (accept) begin
         acc[bit_cnt] <= bit_val;
         bit_cnt      <= last_bit ? '0 : bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_ok)
         mem[wr_ptr] <= new_word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         overflow_cnt <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr_ok && !pop)
            fifo_level <= fifo_level + 1'b1;
         else if (pop && !wr_ok)
            fifo_level <= fifo_level - 1'b1;
         if (drop && overflow_cnt != '1)
            overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

`ifdef RNG_HEALTH_TEST_EN
   logic [7:0] rep_cnt;
   logic [7:0] rep_next;
   logic       prev_bit;

   // A zero count marks "no sample seen yet since reset".
   always_comb begin
      if (rep_cnt == '0 || raw_bit != prev_bit)
         rep_next = 8'd1;
      else if (rep_cnt == '1)
         rep_next = rep_cnt;
      else
         rep_next = rep_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt     <= '0;
         prev_bit    <= 1'b0;
         health_fail <= 1'b0;
      end else begin
         rep_cnt  <= rep_next;
         prev_bit <= raw_bit;
         if (rep_next == 8'(REP_LIMIT))
            health_fail <= 1'b1;
      end
   end

   assign collect_en = !health_fail;
`else
   assign health_fail = 1'b0;
   assign collect_en  = 1'b1;
`endif

endmodule

// File: doc/entropy_collector.md
ENTROPY_COLLECTOR -- requirements
Module: entropy_collector

Interface
REQ-001 Parameter WORD_WIDTH, default 8: bits per output word; legal range 2..32.
REQ-002 Parameter FIFO_DEPTH, default 16: output FIFO entries; a power of two, at least 2.
REQ-003 Parameter DEBIAS, default 1: 1 = von Neumann de-bias; 0 = raw pass-through, one bit per cycle.
REQ-004 Parameter REP_LIMIT, default 32: repetition-count health-test threshold; legal range 2..255.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 raw_bit  input  1  raw entropy sample (XOR of ring oscillators), sampled every clk edge.
REQ-009 out_word  output  WORD_WIDTH  FIFO head word (first-word fall-through).
REQ-010 out_valid  output  1  high while the FIFO holds at least one word.
REQ-011 out_ready  input  1  consumer accepts out_word on an edge where out_valid and out_ready are both high.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words stored.
REQ-013 overflow_cnt  output  16  number of completed words dropped because the FIFO was full; saturates at 0xFFFF.
REQ-014 health_fail  output  1  sticky flag: the health test tripped.

Function
REQ-015 With DEBIAS=1, a pair-phase bit SHALL toggle every cycle. Phase 0 stores raw_bit as the first sample. Phase 1 compares raw_bit with the stored first sample.
REQ-016 Phase 1 with first=0, second=1 SHALL yield bit 1; first=1, second=0 SHALL yield bit 0; equal samples SHALL yield no bit.
REQ-017 With DEBIAS=0, every cycle's raw_bit SHALL be accepted as a new bit.
REQ-018 Accepted bits SHALL fill the accumulator LSB-first: the k-th accepted bit goes to bit k.
REQ-019 On the edge that accepts bit WORD_WIDTH-1, the completed word, including that bit, SHALL be written to the FIFO on that same edge. The bit counter SHALL wrap to 0.
REQ-020 Word-write latency: if the FIFO was empty, out_valid SHALL be high in the cycle after the write edge, with out_word equal to the written word.
REQ-021 A pop SHALL occur when out_valid and out_ready are both high. Words SHALL leave in write order.
REQ-022 Write while full without a pop: the word SHALL be dropped and overflow_cnt SHALL increment by 1, saturating.
REQ-023 Write and pop on the same edge: both SHALL be performed, including when the FIFO is full; fifo_level is unchanged and there is no overflow.
REQ-024 Pop while empty SHALL NOT occur, because out_valid is low; out_ready is ignored when the FIFO is empty.
REQ-025 out_word SHALL hold its value while out_valid is high and no pop occurs.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-027 Reset SHALL clear the pair phase, stored first sample, accumulator, bit counter, FIFO pointers, fifo_level, overflow_cnt, the health counter and health_fail.
REQ-028 Output values during and after reset: out_valid=0, fifo_level=0, overflow_cnt=0, health_fail=0; out_word is don't-care while out_valid=0.
REQ-029 Reset asserted mid-word or mid-pair SHALL discard the partial word and all FIFO contents.
REQ-030 The first cycle after reset deasserts SHALL be pair phase 0.

Configuration
REQ-031 Macro RNG_HEALTH_TEST_EN, when defined, SHALL compile in the repetition-count test:
- an 8-bit counter counts consecutive identical raw_bit samples;
- it resets to 1 when raw_bit changes;
- when the count reaches REP_LIMIT, health_fail SHALL be set on that edge.
REQ-032 With the macro defined and health_fail=1:
- no further words SHALL be written to the FIFO and overflow_cnt SHALL NOT change;
- pops continue;
- only reset clears health_fail.
REQ-033 With the macro undefined, the health logic SHALL be absent, health_fail SHALL be tied to 0, and collection SHALL never be paused.

Verification
REQ-034 WORD_WIDTH=8, DEBIAS=1: raw_bit 0,1 repeated for 16 cycles -> exactly one word 0xFF; out_valid high in cycle 17; fifo_level=1.
REQ-035 DEBIAS=1: raw_bit 0,0,1,1 repeated for 64 cycles -> no word written; out_valid stays 0.
REQ-036 FIFO_DEPTH=4, out_ready=0: produce six words 0x01..0x06 -> fifo_level=4, overflow_cnt=2; then out_ready=1 -> 0x01, 0x02, 0x03, 0x04 emitted in order.
REQ-037 FIFO full with out_ready=1 on the write edge -> fifo_level stays 4, overflow_cnt unchanged, the new word appears last.
REQ-038 RNG_HEALTH_TEST_EN defined, REP_LIMIT=32: raw_bit held at 1 for 32 cycles -> health_fail=1 after the 32nd edge, FIFO writes stop; same stimulus with the macro undefined -> health_fail stays 0.
REQ-039 Reset pulsed after 5 accepted bits -> fifo_level=0; the next 8 accepted bits form a clean word with no residue from before reset.
